// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the EX stage and the multiply/divide unit
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, A, B, input busy, hi, lo);
  modport slave (input start, op, A, B, output busy, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle mult/multu/div/divu with HI/LO registers and mthi/mtlo.
// Define MULDIV_MADD_EN to add madd/msub (signed accumulate into {HI,LO}).
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [2:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, q_s, r_s, q_u, r_u;
  logic [2*WIDTH-1:0] mul_s, mul_u, res;
  logic arith, issue, move, done;
`ifdef MULDIV_MADD_EN
  assign arith = bus.op[2:1] != 2'b10;
`else
  assign arith = !bus.op[2];
`endif
  always_comb begin
    issue = state == IDLE && bus.start && arith;
    move = state == IDLE && bus.start && bus.op[2:1] == 2'b10;
    done = state == RUN && cnt == CW'(1);
    state_d = issue ? RUN : done ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  // Sign-extending to 2*WIDTH keeps the low 2*WIDTH bits equal to the signed product
  assign mul_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign mul_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign q_s = $signed(a_q) / $signed(b_q);
  assign r_s = $signed(a_q) % $signed(b_q);
  assign q_u = a_q / b_q;
  assign r_u = a_q % b_q;
  always_comb begin
    res = mul_s;
    case (op_q)
      3'b001: res = mul_u;
      3'b010: res = b_q == '0 ? {a_q, ONES} : (a_q == MIN && b_q == ONES) ? {{WIDTH{1'b0}}, a_q} : {r_s, q_s};
      3'b011: res = b_q == '0 ? {a_q, ONES} : {r_u, q_u};
`ifdef MULDIV_MADD_EN
      3'b110: res = {hi_q, lo_q} + mul_s;
      3'b111: res = {hi_q, lo_q} - mul_s;
`endif
      default: res = mul_s;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (issue) begin
        op_q <= bus.op;
        a_q <= bus.A;
        b_q <= bus.B;
        cnt <= bus.op[2:1] == 2'b01 ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (state == RUN) cnt <= cnt - CW'(1);
      if (move && !bus.op[0]) hi_q <= bus.A;
      if (move && bus.op[0]) lo_q <= bus.A;
      if (done) {hi_q, lo_q} <= res;
    end
  assign bus.busy = state == RUN;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit (WIDTH=32, 5/10 cycle latencies)
module tb_muldiv_unit;
  logic clk = 0;
  logic reset = 0;
  int tests = 0;
  int fails = 0;
  int cyc;
  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Issue on one edge, then count negedges with busy high (bounded)
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    @(negedge clk);
    bus.start = 1;
    bus.op = op;
    bus.A = a;
    bus.B = b;
    @(negedge clk);
    bus.start = 0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    bus.start = 0;
    bus.op = 0;
    bus.A = 0;
    bus.B = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    reset = 1;
    run(3'b000, 32'hFFFFFFFE, 32'd3, cyc);
    check("mult_cyc", 64'(cyc), 64'd5);
    check("mult_hi", 64'(bus.hi), 64'hFFFFFFFF);
    check("mult_lo", 64'(bus.lo), 64'hFFFFFFFA);
    run(3'b001, 32'hFFFFFFFE, 32'd3, cyc);
    check("multu_cyc", 64'(cyc), 64'd5);
    check("multu_hi", 64'(bus.hi), 64'h2);
    check("multu_lo", 64'(bus.lo), 64'hFFFFFFFA);
    run(3'b010, 32'hFFFFFFF9, 32'd2, cyc);
    check("div_cyc", 64'(cyc), 64'd10);
    check("div_lo", 64'(bus.lo), 64'hFFFFFFFD);
    check("div_hi", 64'(bus.hi), 64'hFFFFFFFF);
    run(3'b011, 32'd7, 32'd0, cyc);
    check("divz_cyc", 64'(cyc), 64'd10);
    check("divz_lo", 64'(bus.lo), 64'hFFFFFFFF);
    check("divz_hi", 64'(bus.hi), 64'd7);
    run(3'b010, 32'h80000000, 32'hFFFFFFFF, cyc);
    check("ovf_cyc", 64'(cyc), 64'd10);
    check("ovf_lo", 64'(bus.lo), 64'h80000000);
    check("ovf_hi", 64'(bus.hi), 64'd0);
    @(negedge clk);
    bus.start = 1;
    bus.op = 3'b100;
    bus.A = 32'h12345678;
    @(negedge clk);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    check("mthi_hi", 64'(bus.hi), 64'h12345678);
    bus.op = 3'b101;
    bus.A = 32'h9ABCDEF0;
    @(negedge clk);
    bus.start = 0;
    check("mtlo_busy", 64'(bus.busy), 64'd0);
    check("mtlo_lo", 64'(bus.lo), 64'h9ABCDEF0);
    check("mtlo_hi", 64'(bus.hi), 64'h12345678);
    // A start with new operands during RUN must be ignored
    @(negedge clk);
    bus.start = 1;
    bus.op = 3'b000;
    bus.A = 32'd6;
    bus.B = 32'd7;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.start = 1;
        bus.op = 3'b011;
        bus.A = 32'd100;
        bus.B = 32'd3;
      end
      if (i == 3) bus.start = 0;
      if (!bus.busy) break;
      cyc++;
    end
    check("ign_cyc", 64'(cyc), 64'd5);
    check("ign_hi", 64'(bus.hi), 64'd0);
    check("ign_lo", 64'(bus.lo), 64'd42);
    @(negedge clk);
    check("ign_idle", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.start = 1;
    bus.op = 3'b010;
    bus.A = 32'd100;
    bus.B = 32'd7;
    @(negedge clk);
    bus.start = 0;
    repeat (2) @(negedge clk);
    #2 reset = 0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_hi", 64'(bus.hi), 64'd0);
    check("arst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset = 1;
    repeat (15) @(negedge clk);
    check("arst_nowb_busy", 64'(bus.busy), 64'd0);
    check("arst_nowb_hi", 64'(bus.hi), 64'd0);
    check("arst_nowb_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    bus.start = 1;
    bus.op = 3'b101;
    bus.A = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start = 0;
    check("acc_pre_lo", 64'(bus.lo), 64'hFFFFFFFF);
    run(3'b110, 32'd1, 32'd1, cyc);
`ifdef MULDIV_MADD_EN
    check("madd_cyc", 64'(cyc), 64'd5);
    check("madd_hi", 64'(bus.hi), 64'd1);
    check("madd_lo", 64'(bus.lo), 64'd0);
`else
    check("madd_cyc", 64'(cyc), 64'd0);
    check("madd_hi", 64'(bus.hi), 64'd0);
    check("madd_lo", 64'(bus.lo), 64'hFFFFFFFF);
`endif
    run(3'b111, 32'd1, 32'd1, cyc);
`ifdef MULDIV_MADD_EN
    check("msub_cyc", 64'(cyc), 64'd5);
`else
    check("msub_cyc", 64'(cyc), 64'd0);
`endif
    check("msub_hi", 64'(bus.hi), 64'd0);
    check("msub_lo", 64'(bus.lo), 64'hFFFFFFFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with HI/LO result registers. It sits beside the single-cycle ALU in the EX stage of the pipelined MIPS core. It executes mult/multu/div/divu and mthi/mtlo, and raises `busy` so the hazard unit stalls dependent mfhi/mflo and further muldiv instructions. Latencies are parameters, so the same RTL serves fast-simulation and realistic-timing builds.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width in bits; must be ≥ 2.
- `MULT_CYCLES`, 5: busy cycles for mult/multu/madd/msub; must be ≥ 1.
- `DIV_CYCLES`, 10: busy cycles for div/divu; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe; sampled only while `busy`=0.
- `op`  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 msub.
- `A`  in  WIDTH  rs operand.
- `B`  in  WIDTH  rt operand.
- `busy`  out  WIDTH-independent 1  high while an arithmetic op is in flight.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN. A down-counter tracks the remaining RUN cycles, sized for max(MULT_CYCLES, DIV_CYCLES).
- IDLE with `start`=1 and an arithmetic op:
  - latch `op`, `A` and `B`;
  - load the counter with the op's latency;
  - go to RUN.
- IDLE with `start`=1 and mthi/mtlo: write `A` into HI or LO at that edge. Stay in IDLE; `busy` is never asserted.
- RUN:
  - the counter decrements each cycle;
  - when it reaches the final cycle, HI/LO are written and the state returns to IDLE at the same edge.
  - `start` is ignored throughout RUN; the hazard unit guarantees it stalls instead.
- Result computation:
  - mult: signed 2·WIDTH product; HI takes the upper half, LO the lower half.
  - multu: the same, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: the same, unsigned.
- Divide by zero (div/divu): LO = all ones, HI = A. No exception.
- Signed overflow (div with A = −2^(WIDTH−1), B = −1): LO = A, HI = 0.
- Results come from latched operands only. Changes on `A`/`B` during RUN have no effect.
- `busy` = 1 exactly when the state is RUN.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, `busy`=0, `hi`=0, `lo`=0, counter cleared. An op in flight is aborted and nothing is written back.
- Reset release is synchronous to `clk`. The first issue is accepted at the first rising edge with `reset`=1.
- Arithmetic issue accepted at edge E:
  - `busy`=1 after E;
  - new `hi`/`lo` and `busy`=0 visible after edge E+N, where N = MULT_CYCLES or DIV_CYCLES;
  - `busy` is therefore high for exactly N cycles.
- Back-to-back issue: a new `start` is accepted at edge E+N+0 only if `busy` was sampled 0. The earliest next issue is the edge after `busy` falls. With N=1, ops issue every 2 cycles.
- mthi/mtlo: zero latency beyond the write edge. The value is visible after that edge.
- `hi`/`lo` are registered outputs and hold their value during RUN (old values remain readable).

## Configuration
- `MULDIV_MADD_EN` defined:
  - op 110 (madd) and op 111 (msub) are supported, both signed with MULT_CYCLES latency;
  - madd computes {HI,LO} + A·B; msub computes {HI,LO} − A·B;
  - the accumulation uses {HI,LO} as sampled at the writeback edge and wraps modulo 2^(2·WIDTH).
- `MULDIV_MADD_EN` undefined: ops 110/111 with `start`=1 are ignored. `busy` stays 0 and HI/LO are unchanged.

## Test plan
- Reset, then mult with A=0xFFFFFFFE (−2), B=3 → `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div with A=−7 (0xFFFFFFF9), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with A=7, B=0 → LO=0xFFFFFFFF, HI=7; div with A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles → `busy` never rises; HI/LO hold those values after each write edge.
- Issue mult, then pulse `start` with op=divu and change A/B during RUN → the second start is ignored; the result matches the first operands; `busy` falls exactly at E+5.
- Drop `reset` at cycle 3 of a div → `busy`, `hi`, `lo` go to 0 immediately (not waiting for an edge); no writeback after release.
- With `MULDIV_MADD_EN`: HI=0, LO=0xFFFFFFFF, then madd A=1, B=1 → HI=1, LO=0; msub A=1, B=1 → HI=0, LO=0xFFFFFFFF. Without the macro, the same stimulus leaves HI/LO unchanged and `busy`=0.
